// File: rtl/mux4_sel_sequencer.sv
// Serializer feeding a 4:1 gate-level mux: holds a loaded word on the mux inputs and
// walks the select lines, streaming the mux output (plus optional parity) downstream.
module mux4_sel_sequencer #(
    parameter bit DESCEND = 1'b0,
    parameter bit PARITY  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [0:3] load_data,
    output logic       load_ready,
    output logic [0:3] mux_in,
    output logic [0:1] sel,
    input  logic       mux_out,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_last,
    input  logic       ser_ready,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic [0:1] sel_q, sel_d;
    logic [0:3] word_q, word_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic beat_fire;
    logic frame_done;
    logic accept;

    function automatic logic [1:0] beat_to_sel(input logic [1:0] beat);
        return DESCEND ? ~beat : beat;
    endfunction

    function automatic logic even_parity(input logic [0:3] word);
        return ^word;
    endfunction

    always_comb begin
        ser_valid  = (state_q != IDLE);
        busy       = (state_q != IDLE);
        ser_last   = (state_q == PAR) ||
                     ((state_q == DATA) && (beat_q == 2'd3) && !PARITY);
        // Parity beat bypasses the mux; data beats pass the mux output straight through.
        ser_bit    = (state_q == PAR) ? even_parity(word_q) : mux_out;
        load_ready = (state_q == IDLE) || (ser_last && ser_ready);
        beat_fire  = ser_valid && ser_ready;
        frame_done = ser_last && beat_fire;
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        word_d      = word_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = load_data;
                    beat_d  = 2'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_fire) begin
                    if (beat_q == 2'd3) begin
                        if (PARITY) begin
                            state_d = PAR;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            PAR: begin
                state_d = PAR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame end: count it, then either chain straight into the next word or go idle.
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            beat_d      = 2'd0;
            if (accept) begin
                word_d  = load_data;
                state_d = DATA;
            end else begin
                state_d = IDLE;
            end
        end

        sel_d = beat_to_sel(beat_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            sel_q       <= beat_to_sel(2'd0);
            word_q      <= 4'b0000;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            sel_q       <= sel_d;
            word_q      <= word_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mux_in    = word_q;
    assign sel       = sel_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/mux4_sel_sequencer.md
# mux4_sel_sequencer

Serializer stage that sits directly upstream of the 4-to-1 gate-level mux. It accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the mux select lines through all four positions, presenting the mux output as a serial valid/ready bit stream, optionally followed by an even-parity beat. A wrapping word counter reports completed frames.

## Interface

Parameters:
- `DESCEND`, default 0: 0 steps select 00→01→10→11; 1 steps select 11→10→01→00.
- `PARITY`, default 0: 1 appends a fifth beat carrying the even parity (XOR) of the held word.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `load_valid` input, 1: upstream word valid.
- `load_data` input, [0:3]: upstream word; bit 0 is the first bit in ascending order.
- `load_ready` output, 1: block accepts `load_data` this cycle.
- `mux_in` output, [0:3]: held word; wired to the mux `in`.
- `sel` output, [0:1]: registered select; wired to the mux `select`.
- `mux_out` input, 1: mux `out`, fed back combinationally.
- `ser_bit` output, 1: serial data. Equals `mux_out` on data beats and the parity bit on the parity beat.
- `ser_valid` output, 1: `ser_bit` valid.
- `ser_last` output, 1: final beat of the frame.
- `ser_ready` input, 1: downstream accepts the beat.
- `busy` output, 1: a frame is in progress.
- `frame_cnt` output, [7:0]: count of completed frames.

## Operation

- FSM states: IDLE, DATA, PAR.
- IDLE:
  - `load_ready`=1 and `ser_valid`=0.
  - On `load_valid`&&`load_ready`: capture `load_data` into `mux_in`, load `sel` with the first position (00, or 11 if `DESCEND`), and go to DATA.
- DATA:
  - `ser_valid`=1 and `ser_bit`=`mux_out`.
  - `sel` advances by one position only on a `ser_valid`&&`ser_ready` beat; otherwise `sel` and `mux_in` are held.
  - Beat index is 0..3. After the handshake on beat 3: go to PAR if `PARITY`; otherwise end the frame.
- PAR:
  - `ser_valid`=1 and `ser_bit`=^`mux_in`.
  - `sel` holds its last value.
  - After the handshake, end the frame.
- Frame end:
  - `frame_cnt` increments by 1, wrapping 255→0.
  - If `load_valid` is high in the same cycle, the new word is captured and the FSM re-enters DATA with the first `sel` position. There is no idle bubble.
  - Otherwise the FSM returns to IDLE.
- `load_ready` = (state==IDLE) || (`ser_last` && `ser_ready`). This is a combinational path from `ser_ready`.
- `ser_last` = 1 on beat 3 when `PARITY`=0, or on the PAR beat when `PARITY`=1.
- `busy` = (state!=IDLE).
- `load_data` presented while `load_ready`=0 is ignored; upstream must hold it.
- Width rules: the beat counter is 2 bits, and `sel` is derived from it (inverted when `DESCEND`).
- Reset asserted mid-frame: the frame is aborted, no count increment occurs, and all outputs return to their reset values immediately.

## Timing

- Reset values:
  - state=IDLE, `sel`=00 (11 if `DESCEND`), `mux_in`=0000, `frame_cnt`=0.
  - `ser_valid`=0, `ser_last`=0, `busy`=0, `load_ready`=1, `ser_bit`=`mux_out`.
- The first beat is valid in the cycle after load acceptance.
- With `ser_ready` held high, a frame takes 4 cycles (5 with `PARITY`), and frames run back-to-back at full throughput.
- `ser_bit` is combinational from the registered `sel`/`mux_in` through the mux. It is stable for the whole cycle and settles within one mux gate-delay path.
- `ser_ready` low stalls indefinitely. All state is held, and `ser_valid` stays at 1 (it never drops mid-frame).
- `frame_cnt` updates on the clock edge that completes the last beat.

## Test plan

- Reset, then load 1011 with `ser_ready`=1 and `DESCEND`=0 → `sel` sequence 00,01,10,11; `ser_bit` sequence 1,0,1,1; `ser_last` on the 4th beat; `frame_cnt`=1; return to IDLE.
- `DESCEND`=1, `PARITY`=1, load 1101 → `ser_bit` sequence 1,0,1,1 then parity 1; `ser_last` only on the 5th beat; `sel` held at 00 during the parity beat.
- Load 0110, drop `ser_ready` for 3 cycles on beat 2 → `sel`=01 is held with `ser_valid`=1 and `ser_bit`=1 throughout; the stream resumes as 1,0 with no lost or duplicated beats.
- `load_valid` held continuously with words 1000, 0001 → `load_ready` pulses only on the last-beat handshake; 8 contiguous valid beats 1,0,0,0,0,0,0,1; `frame_cnt`=2.
- Assert `rst_n`=0 on beat 2 of a frame → outputs return to reset values immediately, `frame_cnt` is unchanged (0), and the next load starts at `sel`=00.
- Send 256 frames → `frame_cnt` wraps to 0, and frame 257 yields `frame_cnt`=1.
